// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: definitions shared by the fetch stage, the decode stage and
// the bench.
//   FETCH_XLEN      default datapath/address width
//   FETCH_RESET_PC  default PC loaded on reset
//   FETCH_NOP_INSTR bubble encoding (addi x0,x0,0) shown to decode when the
//                   output is not valid
//   fetch_state_e   fetch FSM states:
//                     ISSUE - a request may go out
//                     WAIT  - one live request is outstanding
//                     DROP  - one stale request is outstanding and its
//                             response must be discarded
package fetch_unit_pkg;

  localparam int          FETCH_XLEN      = 32;
  localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register of {instr, pc}. It parks a
// returning instruction while the consumer is stalled.
//   clk, rst          clock and asynchronous active-high reset
//   load              capture load_instr/load_pc and mark the entry full
//   drain             the consumer took the entry, so mark it empty
//   clear             flush; this wins over load and drain
//   full, instr, pc   entry state and contents
// The contents are meaningless while full=0, so clear and drain only drop
// the full flag.
module fetch_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [31:0]     load_instr,
  input  logic [XLEN-1:0] load_pc,
  input  logic            drain,
  input  logic            clear,
  output logic            full,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      full  <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (drain) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the RV32 pipeline.
// It owns the PC and keeps at most one word request outstanding to
// instruction memory. It hands {instr, pc, valid} to decode through an
// output register. A one-entry skid buffer catches a response that returns
// while decode is stalled.
//   clk, rst                   clock and asynchronous active-high reset
//   imem_req, imem_addr        request strobe and word address; the strobe is
//                              combinational so that a reply can trigger the
//                              next request in the same cycle
//   imem_rdata, imem_valid     in-order response
//   stall_i                    decode cannot take a new instruction this cycle
//   redirect_i, redirect_pc_i  flush and restart at redirect_pc_i (bits [1:0]
//                              are dropped)
//   instr_decode, pc_decode,
//   valid_decode               registered output to decode; a bubble carries
//                              NOP_INSTR and pc 0
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN      = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(FETCH_RESET_PC),
  parameter logic [31:0]     NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [31:0]     instr_decode,
  output logic [XLEN-1:0] pc_decode,
  output logic            valid_decode
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] opc_q, opc_d;
  logic            vld_q, vld_d;

  logic            sb_load, sb_drain, sb_clear, sb_full;
  logic [31:0]     sb_instr;
  logic [XLEN-1:0] sb_pc;

  // A reply counts only for a live request. In DROP the reply belongs to a
  // flushed request. In ISSUE nothing is owed, so a reply is a protocol error.
  logic rsp;
  assign rsp = imem_valid && (state_q == WAIT);

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (sb_load),
    .load_instr (imem_rdata),
    .load_pc    (pc_q),
    .drain      (sb_drain),
    .clear      (sb_clear),
    .full       (sb_full),
    .instr      (sb_instr),
    .pc         (sb_pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    opc_d     = opc_q;
    vld_d     = vld_q;
    sb_load   = 1'b0;
    sb_drain  = 1'b0;
    sb_clear  = 1'b0;
    imem_req  = 1'b0;
    imem_addr = pc_q;

    if (redirect_i) begin
      instr_d  = NOP_INSTR;
      opc_d    = '0;
      vld_d    = 1'b0;
      sb_clear = 1'b1;
      pc_d     = redirect_pc_i & ALIGN_MASK;
      // If a request is still owed, its reply must be swallowed before the
      // new target is fetched.
      if ((state_q == WAIT || state_q == DROP) && !imem_valid)
        state_d = DROP;
      else
        state_d = ISSUE;
    end else begin
      // The output register holds during a stall. Otherwise the parked entry
      // goes first. It cannot coincide with a reply because no request is
      // issued while the buffer is full.
      if (!stall_i) begin
        if (sb_full) begin
          instr_d  = sb_instr;
          opc_d    = sb_pc;
          vld_d    = 1'b1;
          sb_drain = 1'b1;
        end else if (rsp) begin
          instr_d  = imem_rdata;
          opc_d    = pc_q;
          vld_d    = 1'b1;
        end else begin
          instr_d  = NOP_INSTR;
          opc_d    = '0;
          vld_d    = 1'b0;
        end
      end else if (rsp && !sb_full) begin
        sb_load = 1'b1;
      end

      if (rsp) pc_d = pc_q + XLEN'(4);

      // A request goes out only if the skid buffer will be empty afterwards.
      // With stall_i low a full buffer drains this cycle, so stall_i alone
      // decides.
      case (state_q)
        ISSUE: begin
          if (!stall_i) begin
            imem_req = 1'b1;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (imem_valid) begin
            if (!stall_i) begin
              imem_req  = 1'b1;     // back-to-back: fetch pc+4 now
              imem_addr = pc_d;
            end else begin
              state_d   = ISSUE;
            end
          end
        end
        DROP: begin
          if (imem_valid) state_d = ISSUE;
        end
        default: state_d = ISSUE;
      endcase
    end

    // A strobe must not leak out while the block is held in reset.
    if (rst) imem_req = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC & ALIGN_MASK;
      instr_q <= NOP_INSTR;
      opc_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      vld_q   <= vld_d;
    end
  end

  assign instr_decode = instr_q;
  assign pc_decode    = opc_q;
  assign valid_decode = vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. An in-order memory model answers each request
// "lat" cycles later with data addr|0x13. A queue-based reference model of
// the fetch rules is checked every cycle. Per-cycle logs are then checked
// against hand-derived literals for each scenario.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic        stall_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] instr_decode, pc_decode;
  logic        valid_decode;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_decode(instr_decode), .pc_decode(pc_decode), .valid_decode(valid_decode)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0, lat = 1;
  bit allow_stray = 1'b0;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  mreq_t memq[$];

  // reference model
  logic [31:0] m_pc, m_oinstr, m_opc;
  bit          m_ovld, m_outst, m_stale;
  ent_t        m_buf[$];

  // per-cycle log, indexed by cycle number since reset release
  bit          vld_at[64], req_at[64];
  logic [31:0] pc_at[64], instr_at[64], addr_at[64];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = FETCH_RESET_PC; m_oinstr = FETCH_NOP_INSTR; m_opc = '0;
    m_ovld = 0; m_outst = 0; m_stale = 0; m_buf.delete();
  endtask

  task automatic out_bubble();
    m_oinstr = FETCH_NOP_INSTR; m_opc = '0; m_ovld = 0;
  endtask

  // Called mid-cycle: inputs are stable and combinational outputs have settled.
  task automatic model_step();
    bit got, fresh, exp_req;
    ent_t e, e2;
    if (rst) begin
      chk("rst_valid", {31'd0, valid_decode}, 32'd0);
      chk("rst_instr", instr_decode, FETCH_NOP_INSTR);
      chk("rst_pc", pc_decode, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      model_reset();
      return;
    end
    assert (!imem_valid || m_outst || allow_stray)
      else $error("protocol: imem_valid with no request owed at cyc %0d", cyc);

    chk("valid", {31'd0, valid_decode}, {31'd0, m_ovld});
    chk("instr", instr_decode, m_oinstr);
    if (m_ovld) chk("pc", pc_decode, m_opc);
    if (cyc < 64) begin
      vld_at[cyc] = valid_decode; pc_at[cyc] = pc_decode; instr_at[cyc] = instr_decode;
      req_at[cyc] = imem_req; addr_at[cyc] = imem_addr;
    end

    got   = imem_valid && m_outst;
    fresh = got && !m_stale;
    e.instr = imem_rdata; e.pc = m_pc;
    if (got) m_outst = 0;
    if (redirect_i) begin
      out_bubble();
      m_buf.delete();
      m_pc = redirect_pc_i & ~32'd3;
      m_stale = m_outst;            // still owed -> its reply is stale
    end else begin
      if (got) m_stale = 0;
      if (fresh) m_pc = m_pc + 32'd4;
      if (stall_i) begin
        if (fresh) m_buf.push_back(e);
      end else if (m_buf.size() > 0) begin
        e2 = m_buf.pop_front();
        m_oinstr = e2.instr; m_opc = e2.pc; m_ovld = 1;
      end else if (fresh) begin
        m_oinstr = e.instr; m_opc = e.pc; m_ovld = 1;
      end else begin
        out_bubble();
      end
    end
    exp_req = !redirect_i && !stall_i && !m_outst && (m_buf.size() == 0) && !(got && !fresh);
    chk("req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) begin
      chk("addr", imem_addr, m_pc);
      m_outst = 1; m_stale = 0;
    end
  endtask

  task automatic step();
    mreq_t r;
    @(negedge clk);
    model_step();
    if (rst) memq.delete();
    else if (imem_req) begin
      r.addr = imem_addr; r.due = cyc + lat; memq.push_back(r);
    end
    @(posedge clk); #1;
    cyc++;
    imem_valid = 1'b0; imem_rdata = '0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_valid = 1'b1; imem_rdata = memq[0].addr | 32'h13;
      void'(memq.pop_front());
    end
  endtask

  task automatic do_reset(int l);
    rst = 1; stall_i = 0; redirect_i = 0; lat = l; imem_valid = 0;
    repeat (2) step();
    rst = 0; cyc = 1;
    for (int i = 0; i < 64; i++) begin
      vld_at[i] = 0; req_at[i] = 0; pc_at[i] = '0; instr_at[i] = '0; addr_at[i] = '0;
    end
  endtask

  initial begin
    // 1) 1-cycle memory: full throughput after reset
    do_reset(1);
    repeat (7) step();
    chk("t1_req1", {31'd0, req_at[1]}, 32'd1);
    chk("t1_addr1", addr_at[1], 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_vld", {31'd0, vld_at[3+i]}, 32'd1);
      chk("t1_pc", pc_at[3+i], 32'(4*i));
    end
    chk("t1_instr8", instr_at[5], 32'h1b);

    // 2) 3-cycle memory: one instruction per 3 cycles
    do_reset(3);
    repeat (12) step();
    for (int i = 0; i < 3; i++) begin
      chk("t2_req", {31'd0, req_at[1+3*i]}, 32'd1);
      chk("t2_addr", addr_at[1+3*i], 32'(4*i));
      chk("t2_vld", {31'd0, vld_at[5+3*i]}, 32'd1);
      chk("t2_pc", pc_at[5+3*i], 32'(4*i));
    end
    chk("t2_noreq2", {31'd0, req_at[2]}, 32'd0);
    chk("t2_bub6", {31'd0, vld_at[6]}, 32'd0);
    chk("t2_nop6", instr_at[6], FETCH_NOP_INSTR);

    // 3) 4-cycle stall while pc 8 returns: skid catches it, no loss/duplicate
    do_reset(1);
    repeat (3) step();
    stall_i = 1; repeat (4) step();
    stall_i = 0; repeat (4) step();
    chk("t3_frozen_vld", {31'd0, vld_at[8]}, 32'd1);
    chk("t3_frozen_pc", pc_at[8], 32'h4);
    for (int c = 4; c < 8; c++) chk("t3_noreq", {31'd0, req_at[c]}, 32'd0);
    chk("t3_req8", {31'd0, req_at[8]}, 32'd1);
    chk("t3_addr8", addr_at[8], 32'hc);
    chk("t3_pc9", pc_at[9], 32'h8);
    chk("t3_pc10", pc_at[10], 32'hc);
    chk("t3_vld10", {31'd0, vld_at[10]}, 32'd1);

    // 4) redirect to 0x43 while waiting on 0x10 (3-cycle memory)
    do_reset(3);
    repeat (13) step();
    redirect_i = 1; redirect_pc_i = 32'h43; step();
    redirect_i = 0; repeat (8) step();
    chk("t4_addr13", addr_at[13], 32'h10);
    for (int c = 14; c < 17; c++) chk("t4_noreq", {31'd0, req_at[c]}, 32'd0);
    chk("t4_req17", {31'd0, req_at[17]}, 32'd1);
    chk("t4_addr17", addr_at[17], 32'h40);
    for (int c = 15; c < 21; c++) chk("t4_bubble", {31'd0, vld_at[c]}, 32'd0);
    chk("t4_vld21", {31'd0, vld_at[21]}, 32'd1);
    chk("t4_pc21", pc_at[21], 32'h40);
    chk("t4_instr21", instr_at[21], 32'h53);

    // 5a) redirect + stall + imem_valid in one cycle
    do_reset(1);
    repeat (3) step();
    stall_i = 1; redirect_i = 1; redirect_pc_i = 32'h80; step();
    stall_i = 0; redirect_i = 0; repeat (4) step();
    chk("t5a_bub5", {31'd0, vld_at[5]}, 32'd0);
    chk("t5a_addr5", addr_at[5], 32'h80);
    chk("t5a_req5", {31'd0, req_at[5]}, 32'd1);
    chk("t5a_bub6", {31'd0, vld_at[6]}, 32'd0);
    chk("t5a_pc7", pc_at[7], 32'h80);
    chk("t5a_vld7", {31'd0, vld_at[7]}, 32'd1);

    // 5b) redirect while stalled with a full skid buffer: entry is flushed
    do_reset(1);
    repeat (3) step();
    stall_i = 1; repeat (2) step();
    redirect_i = 1; redirect_pc_i = 32'h100; step();
    stall_i = 0; redirect_i = 0; repeat (4) step();
    chk("t5b_pc6", pc_at[6], 32'h4);
    chk("t5b_bub7", {31'd0, vld_at[7]}, 32'd0);
    chk("t5b_bub8", {31'd0, vld_at[8]}, 32'd0);
    chk("t5b_addr7", addr_at[7], 32'h100);
    chk("t5b_pc9", pc_at[9], 32'h100);
    chk("t5b_vld9", {31'd0, vld_at[9]}, 32'd1);

    // 6) async reset with a full skid buffer, then a stray reply after release
    do_reset(1);
    repeat (3) step();
    stall_i = 1; step();
    #2 rst = 1;
    #1;
    chk("t6_async_vld", {31'd0, valid_decode}, 32'd0);
    chk("t6_async_instr", instr_decode, FETCH_NOP_INSTR);
    chk("t6_async_pc", pc_decode, 32'd0);
    chk("t6_async_req", {31'd0, imem_req}, 32'd0);
    do_reset(1);
    imem_valid = 1; imem_rdata = 32'hDEAD_BEEF; allow_stray = 1;
    step();
    allow_stray = 0;
    repeat (4) step();
    chk("t6_addr1", addr_at[1], 32'h0);
    chk("t6_bub2", {31'd0, vld_at[2]}, 32'd0);
    chk("t6_pc3", pc_at[3], 32'h0);
    chk("t6_instr3", instr_at[3], 32'h13);
    chk("t6_vld3", {31'd0, vld_at[3]}, 32'd1);

    // 7) misaligned redirect near the top of memory: low bits dropped, PC wraps
    do_reset(1);
    redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFE; step();
    redirect_i = 0; repeat (5) step();
    chk("t7_addr2", addr_at[2], 32'hFFFF_FFFC);
    chk("t7_addr3", addr_at[3], 32'h0);
    chk("t7_pc4", pc_at[4], 32'hFFFF_FFFC);
    chk("t7_instr4", instr_at[4], 32'hFFFF_FFFF);
    chk("t7_pc5", pc_at[5], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
